// File: rtl/bidcounter_pkg.sv
// Shared definitions for bidcounter and its direction controller.
package bidcounter_pkg;

   localparam int WIDTH_DEFAULT = 4;

   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

   typedef enum logic [1:0] {
      LOW  = 2'd0,
      RISE = 2'd1,
      HIGH = 2'd2,
      FALL = 2'd3
   } db_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchronizer and debouncer; emits one press pulse per accepted rising level.
//
// state | meaning
// LOW   | button accepted as released
// RISE  | button seen high, waiting for it to stay high
// HIGH  | button accepted as pressed
// FALL  | button seen low, waiting for it to stay low
module btn_debounce
   import bidcounter_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic btn_clean,
   output logic press
);

   localparam logic [7:0] DB_LOAD  = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic       DB_SHORT = (DEBOUNCE_CYCLES == 1);

   logic       sync_1;
   logic       btn_s;
   db_state_t  state;
   db_state_t  state_nxt;
   logic [7:0] db_cnt;
   logic [7:0] db_cnt_nxt;
   logic       press_q;
   logic       press_nxt;
   logic       db_tc;

   // db_cnt holds the remaining stable cycles still required
   assign db_tc = (db_cnt <= 8'd1);

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_1  <= 1'b0;
         btn_s   <= 1'b0;
         state   <= LOW;
         db_cnt  <= 8'd0;
         press_q <= 1'b0;
      end else begin
         sync_1  <= btn;
         btn_s   <= sync_1;
         state   <= state_nxt;
         db_cnt  <= db_cnt_nxt;
         press_q <= press_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      db_cnt_nxt = db_cnt;
      press_nxt  = 1'b0;
      unique case (state)
         LOW: begin
            if (btn_s) begin
               if (DB_SHORT) begin
                  state_nxt = HIGH;
                  press_nxt = 1'b1;
               end else begin
                  state_nxt  = RISE;
                  db_cnt_nxt = DB_LOAD;
               end
            end
         end
         RISE: begin
            if (!btn_s) begin
               state_nxt  = LOW;
               db_cnt_nxt = 8'd0;
            end else if (db_tc) begin
               state_nxt  = HIGH;
               db_cnt_nxt = 8'd0;
               press_nxt  = 1'b1;
            end else begin
               db_cnt_nxt = db_cnt - 8'd1;
            end
         end
         HIGH: begin
            if (!btn_s) begin
               if (DB_SHORT) begin
                  state_nxt = LOW;
               end else begin
                  state_nxt  = FALL;
                  db_cnt_nxt = DB_LOAD;
               end
            end
         end
         FALL: begin
            if (btn_s) begin
               state_nxt  = HIGH;
               db_cnt_nxt = 8'd0;
            end else if (db_tc) begin
               state_nxt  = LOW;
               db_cnt_nxt = 8'd0;
            end else begin
               db_cnt_nxt = db_cnt - 8'd1;
            end
         end
         default: begin
            state_nxt  = LOW;
            db_cnt_nxt = 8'd0;
         end
      endcase
   end

   always_comb begin
      btn_clean = (state == HIGH) || (state == FALL);
      press     = press_q;
   end

endmodule

// File: rtl/bidcounter_dir_ctrl.sv
// Direction control for bidcounter: button toggle plus optional ping-pong auto-reverse.
//
// state | meaning
// UP    | ctrl=0, counter increments
// DOWN  | ctrl=1, counter decrements
module bidcounter_dir_ctrl
   import bidcounter_pkg::*;
#(
   parameter int WIDTH           = WIDTH_DEFAULT,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn,
   input  logic             mode,
   input  logic [WIDTH-1:0] count,
   output logic             ctrl,
   output logic             dir_change,
   output logic             btn_clean
);

   localparam logic [WIDTH-1:0] CNT_MAX     = '1;
   localparam logic [WIDTH-1:0] CNT_TURN_UP = CNT_MAX - WIDTH'(1);
   localparam logic [WIDTH-1:0] CNT_TURN_DN = WIDTH'(1);

   logic dir_q;
   logic dir_nxt;
   logic dir_change_q;
   logic press;
   logic turn_up;
   logic turn_dn;
   logic toggle;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .clk      (clk),
      .reset    (reset),
      .btn      (btn),
      .btn_clean(btn_clean),
      .press    (press)
   );

   // Turn one step early: bidcounter samples ctrl on the same edge it changes here
   assign turn_up = mode && (dir_q == DIR_UP) && (count == CNT_TURN_UP);
   assign turn_dn = mode && (dir_q == DIR_DN) && (count == CNT_TURN_DN);
   assign toggle  = press || turn_up || turn_dn;

   always_ff @(posedge clk) begin
      if (reset) begin
         dir_q        <= DIR_UP;
         dir_change_q <= 1'b0;
      end else begin
         dir_q        <= dir_nxt;
         dir_change_q <= toggle;
      end
   end

   always_comb begin
      dir_nxt = dir_q;
      if (toggle) begin
         dir_nxt = ~dir_q;
      end
   end

   always_comb begin
      ctrl       = dir_q;
      dir_change = dir_change_q;
   end

endmodule

// File: tb/tb_bidcounter_dir_ctrl.sv
// Bench for bidcounter_dir_ctrl with a behavioural bidcounter closing the count loop.
module tb_bidcounter_dir_ctrl;

   localparam int WIDTH = 4;
   localparam int DB    = 4;

   typedef struct {
      int cyc;
      bit ctrl;
      int cnt;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             btn;
   logic             mode;
   logic [WIDTH-1:0] count;
   logic             ctrl;
   logic             dir_change;
   logic             btn_clean;

   int         cyc = 0;
   int         n_cmp = 0;
   int         n_bad = 0;
   bit         pp_mon = 1'b0;
   bit         wrap_seen = 1'b0;
   logic [3:0] prev_cnt = '0;
   exp_t       exp_q[$];
   exp_t       e;
   int         p;

   bidcounter_dir_ctrl #(
      .WIDTH(WIDTH),
      .DEBOUNCE_CYCLES(DB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .btn       (btn),
      .mode      (mode),
      .count     (count),
      .ctrl      (ctrl),
      .dir_change(dir_change),
      .btn_clean (btn_clean)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // attached up/down counter
   always @(posedge clk) begin
      if (reset) count <= '0;
      else       count <= ctrl ? count - 1'b1 : count + 1'b1;
   end

   // monitor: every dir_change pulse is matched against the next expected turn
   always @(negedge clk) begin
      if (pp_mon && ((prev_cnt == 4'hF && count == 4'h0) || (prev_cnt == 4'h0 && count == 4'hF)))
         wrap_seen = 1'b1;
      prev_cnt = count;
      if (dir_change === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_dir_change: at cycle %0d ctrl=%0d count=%0d, none expected", cyc, ctrl, count);
         end else begin
            e = exp_q.pop_front();
            if (cyc != e.cyc || ctrl !== e.ctrl || (e.cnt >= 0 && int'(count) != e.cnt)) begin
               n_bad++;
               $display("FAIL dir_change_event: got cycle %0d ctrl=%0d count=%0d, expected cycle %0d ctrl=%0d count=%0d",
                        cyc, ctrl, count, e.cyc, e.ctrl, e.cnt);
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_turn(input int c, input bit d, input int n);
      exp_t t;
      t.cyc  = c;
      t.ctrl = d;
      t.cnt  = n;
      exp_q.push_back(t);
   endtask

   task automatic reset_dut(input bit m, output int rel);
      @(posedge clk);
      #1;
      reset = 1'b1;
      mode  = m;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      rel   = cyc;
   endtask

   initial begin
      // reset with button already held
      reset = 1'b1;
      btn   = 1'b1;
      mode  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_ctrl", int'(ctrl), 0);
      check("reset_btn_clean", int'(btn_clean), 0);
      check("reset_dir_change", int'(dir_change), 0);
      reset = 1'b0;
      p = cyc;
      expect_turn(p + 7, 1'b1, -1);
      wait_cyc(7);
      check("btn_clean_pressed", int'(btn_clean), 1);
      btn = 1'b0;
      wait_cyc(10);
      check("btn_clean_released", int'(btn_clean), 0);

      // glitches shorter than the debounce window
      reset_dut(1'b0, p);
      repeat (5) begin
         btn = 1'b1;
         wait_cyc(3);
         btn = 1'b0;
         wait_cyc(5);
      end
      wait_cyc(5);
      check("glitch_ctrl", int'(ctrl), 0);
      check("glitch_btn_clean", int'(btn_clean), 0);

      // manual mode wraps, then a press reverses
      reset_dut(1'b0, p);
      wait_cyc(20);
      check("manual_ctrl", int'(ctrl), 0);
      check("manual_wrap_count", int'(count), 4);
      expect_turn(p + 27, 1'b1, 11);
      btn = 1'b1;
      wait_cyc(9);
      check("manual_reverse_count", int'(count), 9);
      btn = 1'b0;
      wait_cyc(10);

      // ping-pong from reset
      reset_dut(1'b1, p);
      wrap_seen = 1'b0;
      pp_mon    = 1'b1;
      expect_turn(p + 15, 1'b1, 15);
      expect_turn(p + 30, 1'b0, 0);
      expect_turn(p + 45, 1'b1, 15);
      wait_cyc(46);
      pp_mon = 1'b0;
      check("pingpong_no_wrap", int'(wrap_seen), 0);

      // press coinciding with the upper turn point
      reset_dut(1'b1, p);
      expect_turn(p + 15, 1'b1, 15);
      expect_turn(p + 30, 1'b0, 0);
      wait_cyc(8);
      btn = 1'b1;
      wait_cyc(4);
      btn = 1'b0;
      wait_cyc(4);
      check("coincident_count", int'(count), 14);
      wait_cyc(15);

      // reset in the middle of a downward run
      reset_dut(1'b1, p);
      expect_turn(p + 15, 1'b1, 15);
      wait_cyc(21);
      check("midrun_count", int'(count), 9);
      check("midrun_ctrl", int'(ctrl), 1);
      reset = 1'b1;
      wait_cyc(1);
      check("midrun_reset_ctrl", int'(ctrl), 0);
      check("midrun_reset_count", int'(count), 0);
      check("midrun_reset_dir_change", int'(dir_change), 0);
      reset = 1'b0;
      wait_cyc(3);
      check("midrun_resume_count", int'(count), 3);
      check("midrun_resume_ctrl", int'(ctrl), 0);

      wait_cyc(2);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL missed_dir_change: no pulse seen, expected cycle %0d ctrl=%0d count=%0d", e.cyc, e.ctrl, e.cnt);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bidcounter_dir_ctrl.md
# bidcounter_dir_ctrl

Direction controller that sits directly upstream of `bidcounter` and drives its `ctrl` input. It debounces a raw push-button so each clean press toggles the count direction. It also offers a ping-pong mode that reads back `count` and reverses direction at the range ends, so the counter never wraps. It shares `clk` and `reset` with `bidcounter`.

## Interface
- `WIDTH`, default 4: counter width. It must match `bidcounter`. MAX = 2^WIDTH−1.
- `DEBOUNCE_CYCLES`, default 4: number of consecutive cycles the synchronized button must hold a new level before that level is accepted. Legal range is 1..255.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `btn`  in  1: raw asynchronous push-button, active-high.
- `mode`  in  1: 0 = manual (button toggles only), 1 = ping-pong (auto-reverse plus button toggle).
- `count`  in  WIDTH: `bidcounter` output, fed back.
- `ctrl`  out  1: direction to `bidcounter`. 0 = count up, 1 = count down. Registered.
- `dir_change`  out  1: one-cycle pulse, high in the first cycle that `ctrl` shows a new value. Registered.
- `btn_clean`  out  1: debounced button level. Registered.

## Operation
- Synchronizer: a 2-flop chain on `btn` produces `btn_s`. Nothing downstream uses raw `btn`.
- Debounce FSM, with `btn_clean` equal to 1 in HIGH and in FALL:
  - States are LOW, RISE, HIGH, FALL, plus a stability counter `db_cnt`.
  - LOW: if `btn_s`=1, go to RISE with `db_cnt`=1.
  - RISE: if `btn_s`=0, return to LOW. Otherwise increment `db_cnt`; on reaching `DEBOUNCE_CYCLES`, go to HIGH and raise internal `press` for one cycle.
  - HIGH: if `btn_s`=0, go to FALL with `db_cnt`=1.
  - FALL: if `btn_s`=1, return to HIGH. Otherwise count to `DEBOUNCE_CYCLES`, then go to LOW. No event is generated on release.
- Direction FSM, with `ctrl` equal to the state bit:
  - States are UP (`ctrl`=0) and DOWN (`ctrl`=1).
  - `turn_up` = `mode` & UP & (`count` == MAX−1).
  - `turn_dn` = `mode` & DOWN & (`count` == 1).
  - `toggle` = `press` | `turn_up` | `turn_dn`.
  - On `toggle`, the state flips at the next edge. Coincident `press` and `turn_*` produce exactly one flip, never two.
  - `dir_change` is registered as `toggle`.
- Turn points are one short of the bound because `bidcounter` samples `ctrl` at the same edge this block updates it. The required ping-pong sequence is therefore … 13, 14, 15, 14, 13 … 2, 1, 0, 1, 2 …
- Manual mode never looks at `count`. The counter wraps normally: 15→0 going up, 0→15 going down.
- A change of `mode` takes effect from the cycle it is sampled. It never flips direction by itself.
- If ping-pong is entered while `count` already sits at MAX (UP) or 0 (DOWN), one wrap is allowed. Normal turning then resumes.

## Timing
- Reset values, all applied at the first rising edge with `reset`=1:
  - `ctrl`=0, `dir_change`=0, `btn_clean`=0.
  - Debounce FSM in LOW, `db_cnt`=0, synchronizer flops 0.
- Reset mid-debounce or mid-run discards all pending state. No `press` is generated after reset deasserts until a full debounce completes.
- Button latency, from the first edge `btn` is sampled high:
  - `btn_s` is high after 2 edges.
  - `press` occurs after 2+`DEBOUNCE_CYCLES` edges.
  - `ctrl` flips 1 edge after that.
  - Total is 3+`DEBOUNCE_CYCLES` cycles; the default is 7.
- Ping-pong latency: `ctrl` flips at the same edge `count` moves from MAX−1 to MAX (or from 1 to 0).
- A glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no `press`.
- A button held high produces exactly one `press`.

## Structure
- Shared package `bidcounter_pkg` holds:
  - `WIDTH` default.
  - Direction encoding constants: `DIR_UP`=1'b0, `DIR_DN`=1'b1.
  - Debounce state typedef `db_state_t` (LOW, RISE, HIGH, FALL).
- Sub-module `btn_debounce` contains the synchronizer and the debounce FSM, with ports `clk`, `reset`, `btn` → `btn_clean`, `press`. It is reusable for other panel buttons.
- The top level holds the direction FSM and the turn logic.

## Test plan
1. Reset: hold `reset`=1 for 2 cycles with `btn`=1. Required: `ctrl`=0, `btn_clean`=0, `dir_change`=0. After release, `ctrl` flips 7 cycles later with a single `dir_change` pulse.
2. Glitch rejection: pulse `btn` high for 3 cycles (`DEBOUNCE_CYCLES`=4), repeated 5 times. Required: `ctrl` stays 0 and no `dir_change`.
3. Manual wrap: `mode`=0 with `bidcounter` attached and running 20 cycles from reset. Required: count 0..15, 0..3 (wraps) with `ctrl`=0 throughout. Then one clean press: the count reverses (e.g. 5, 4, 3 …).
4. Ping-pong: `mode`=1 from reset for 40 cycles. Required:
   - Count goes 0→15→0→1 … with no 15→0 or 0→15 transition.
   - `ctrl` rises in the cycle `count`=15 and falls in the cycle `count`=0.
   - `dir_change` fires at each turn.
5. Coincident events: `mode`=1, with a press timed so that `press` is asserted exactly when `count`=14 in UP. Required: a single flip and a single `dir_change`.
6. Reset mid-run: assert `reset` in ping-pong while DOWN at `count`=9. Required: next cycle `ctrl`=0, count=0, and counting resumes upward.
